// File: rtl/pacote_processador.sv
// ---------------------------------------------------------------------------
// pacote_processador
// Shared definitions for the program sequencer that feeds the multicycle
// processor: instruction word width, opcode constants, sequencer state
// encoding and a small opcode decode helper.
// No ports (package).
// ---------------------------------------------------------------------------
package pacote_processador;

    localparam int WORD_W    = 16;  // instruction / DIN word width
    localparam int ADDR_W    = 4;   // program memory address width
    localparam int MEM_DEPTH = 16;  // program memory words
    localparam int COUNT_W   = 5;   // issued-word counter, holds 0..16
    localparam int WDOG_W    = 4;   // watchdog counter width

    // Watchdog value seen on the last permitted WAIT cycle without Done
    // (counter starts at 0 on the first WAIT cycle, so this is cycle 15).
    localparam logic [WDOG_W-1:0] WDOG_LAST = 4'd14;

    // Opcode field DIN[8:6]
    localparam logic [2:0] OP_MV  = 3'b000;
    localparam logic [2:0] OP_MVI = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_IMM   = 3'd2,
        ST_WAIT  = 3'd3,
        ST_END   = 3'd4
    } estado_t;

    // mvi is the only two-word instruction: the immediate follows it.
    function automatic logic is_mvi(input logic [2:0] opcode);
        return (opcode == OP_MVI);
    endfunction

endpackage

// File: rtl/memoria_programa.sv
// ---------------------------------------------------------------------------
// memoria_programa
// 16 x 16-bit program store. Synchronous write, combinational read.
// A read of the address being written in the same cycle returns the old
// word, because the array only updates at the clock edge.
// Contents have no reset.
//
// Ports:
//   clock    in   system clock (rising edge)
//   wr_en    in   write enable
//   wr_addr  in   write address
//   wr_data  in   write data
//   rd_addr  in   read address
//   rd_data  out  word at rd_addr (combinational)
// ---------------------------------------------------------------------------
module memoria_programa
    import pacote_processador::*;
(
    input  logic              clock,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WORD_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WORD_W-1:0] rd_data
);

    logic [WORD_W-1:0] mem [MEM_DEPTH];

    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/sequenciador_din.sv
// ---------------------------------------------------------------------------
// sequenciador_din
// Steps through a program held in a small local memory and presents each
// word on DIN of the multicycle processor, pulsing Run once per instruction
// and waiting for Done before issuing the next one. mvi instructions are
// followed by their immediate word one cycle later (Run low). A watchdog
// aborts when Done does not arrive within 15 WAIT cycles.
//
// Configuration macro: SEQUENCIADOR_LOOP_EN
//   defined   -> after Finished the program restarts from PC=0 forever
//   undefined -> after Finished the sequencer returns to IDLE
//
// Ports:
//   Clock     in   system clock (rising edge)
//   Resetn    in   asynchronous active-low reset
//   Start     in   begins program issue when idle
//   ProgLen   in   program length in words (0..16), sampled on Start
//   LoadEn    in   program memory write enable (honoured only when idle)
//   LoadAddr  in   program memory write address
//   LoadData  in   program memory write data
//   Done      in   instruction complete from the processor
//   DIN       out  registered word to the processor
//   Run       out  registered, one cycle per instruction issue
//   Busy      out  high whenever not idle
//   Finished  out  one-cycle pulse on program completion
//   Erro      out  one-cycle pulse on abort (timeout / truncated mvi)
//   PC        out  address of the next word to read
// ---------------------------------------------------------------------------
module sequenciador_din
    import pacote_processador::*;
(
    input  logic               Clock,
    input  logic               Resetn,
    input  logic               Start,
    input  logic [COUNT_W-1:0] ProgLen,
    input  logic               LoadEn,
    input  logic [ADDR_W-1:0]  LoadAddr,
    input  logic [WORD_W-1:0]  LoadData,
    input  logic               Done,
    output logic [WORD_W-1:0]  DIN,
    output logic               Run,
    output logic               Busy,
    output logic               Finished,
    output logic               Erro,
    output logic [ADDR_W-1:0]  PC
);

    estado_t             state,      state_next;
    logic [ADDR_W-1:0]   pc,         pc_next;
    logic [COUNT_W-1:0]  count,      count_next;
    logic [COUNT_W-1:0]  prog_len,   prog_len_next;
    logic [WDOG_W-1:0]   wdog,       wdog_next;
    logic [WORD_W-1:0]   din,        din_next;
    logic                run,        run_next;
    logic                erro,       erro_next;

    logic [WORD_W-1:0]   mem_word;
    logic                mem_wr_en;

    // Loading is only allowed while idle so a running program cannot be
    // modified underneath the sequencer.
    assign mem_wr_en = LoadEn && (state == ST_IDLE);

    memoria_programa u_memoria (
        .clock   (Clock),
        .wr_en   (mem_wr_en),
        .wr_addr (LoadAddr),
        .wr_data (LoadData),
        .rd_addr (pc),
        .rd_data (mem_word)
    );

    // State and datapath registers
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state    <= ST_IDLE;
            pc       <= '0;
            count    <= '0;
            prog_len <= '0;
            wdog     <= '0;
            din      <= '0;
            run      <= 1'b0;
            erro     <= 1'b0;
        end else begin
            state    <= state_next;
            pc       <= pc_next;
            count    <= count_next;
            prog_len <= prog_len_next;
            wdog     <= wdog_next;
            din      <= din_next;
            run      <= run_next;
            erro     <= erro_next;
        end
    end

    // Next-state and next-value logic
    always_comb begin
        state_next    = state;
        pc_next       = pc;
        count_next    = count;
        prog_len_next = prog_len;
        wdog_next     = wdog;
        din_next      = din;
        run_next      = 1'b0;
        erro_next     = 1'b0;

        case (state)
            ST_IDLE: begin
                if (Start) begin
                    prog_len_next = ProgLen;
                    count_next    = '0;
                    if (ProgLen != '0) begin
                        pc_next    = '0;
                        state_next = ST_ISSUE;
                    end else begin
                        // Empty program: report completion without issuing.
                        state_next = ST_END;
                    end
                end
            end

            ST_ISSUE: begin
                din_next   = mem_word;
                run_next   = 1'b1;
                pc_next    = pc + ADDR_W'(1);
                count_next = count + COUNT_W'(1);
                if (is_mvi(mem_word[8:6])) begin
                    state_next = ST_IMM;
                end else begin
                    wdog_next  = '0;
                    state_next = ST_WAIT;
                end
            end

            ST_IMM: begin
                if (count == prog_len) begin
                    // mvi was the last word: its immediate is missing.
                    erro_next  = 1'b1;
                    state_next = ST_IDLE;
                end else begin
                    din_next   = mem_word;
                    pc_next    = pc + ADDR_W'(1);
                    count_next = count + COUNT_W'(1);
                    wdog_next  = '0;
                    state_next = ST_WAIT;
                end
            end

            ST_WAIT: begin
                if (Done) begin
                    state_next = (count == prog_len) ? ST_END : ST_ISSUE;
                end else if (wdog == WDOG_LAST) begin
                    erro_next  = 1'b1;
                    state_next = ST_IDLE;
                end else begin
                    wdog_next = wdog + WDOG_W'(1);
                end
            end

            ST_END: begin
`ifdef SEQUENCIADOR_LOOP_EN
                // An empty program has nothing to repeat.
                if (prog_len != '0) begin
                    pc_next    = '0;
                    count_next = '0;
                    state_next = ST_ISSUE;
                end else begin
                    state_next = ST_IDLE;
                end
`else
                state_next = ST_IDLE;
`endif
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign DIN      = din;
    assign Run      = run;
    assign Busy     = (state != ST_IDLE);
    assign Finished = (state == ST_END);
    assign Erro     = erro;
    assign PC       = pc;

endmodule

// File: tb/tb_sequenciador_din.sv
// ---------------------------------------------------------------------------
// tb_sequenciador_din
// Directed test of sequenciador_din. The stimulus process pushes expected
// output events (Run / Finished / Erro pulses, plus explicit state
// snapshots) into a queue; the monitor process pops and compares each time
// the DUT shows an output event or a snapshot is requested.
// ---------------------------------------------------------------------------
module tb_sequenciador_din;

    logic        Clock = 1'b0;
    logic        Resetn;
    logic        Start;
    logic [4:0]  ProgLen;
    logic        LoadEn;
    logic [3:0]  LoadAddr;
    logic [15:0] LoadData;
    logic        Done;
    logic [15:0] DIN;
    logic        Run;
    logic        Busy;
    logic        Finished;
    logic        Erro;
    logic [3:0]  PC;

    sequenciador_din dut (
        .Clock    (Clock),
        .Resetn   (Resetn),
        .Start    (Start),
        .ProgLen  (ProgLen),
        .LoadEn   (LoadEn),
        .LoadAddr (LoadAddr),
        .LoadData (LoadData),
        .Done     (Done),
        .DIN      (DIN),
        .Run      (Run),
        .Busy     (Busy),
        .Finished (Finished),
        .Erro     (Erro),
        .PC       (PC)
    );

    always #5 Clock = ~Clock;

    typedef struct {
        string       name;
        bit          snapshot;
        logic [15:0] din;
        bit          chk_din;
        logic        run;
        logic        busy;
        logic        fin;
        logic        erro;
        logic [3:0]  pc;
        bit          chk_pc;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    exp_t cur;
    int   cyc       = 0;
    int   checks    = 0;
    int   errors    = 0;
    logic snap      = 1'b0;
    logic final_req = 1'b0;
    bit   bad;

    always @(posedge Clock) cyc <= cyc + 1;

    // ---------------- monitor ----------------
    initial begin
        forever begin
            @(negedge Clock);
            #1;
            if (final_req) begin
                checks++;
                if (sb.size() != 0) begin
                    errors++;
                    $display("FAIL sb_drain: %0d expected events left, required 0", sb.size());
                end
            end else if (snap || Run || Finished || Erro) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_output cyc=%0d: run=%0b fin=%0b erro=%0b din=%h pc=%0d, required no event",
                             cyc, Run, Finished, Erro, DIN, PC);
                end else begin
                    cur = sb.pop_front();
                    bad = (snap != cur.snapshot) || (Run !== cur.run) || (Finished !== cur.fin) ||
                          (Erro !== cur.erro) || (Busy !== cur.busy) ||
                          (cur.chk_din && (DIN !== cur.din)) || (cur.chk_pc && (PC !== cur.pc)) ||
                          ((cur.cyc >= 0) && (cyc != cur.cyc));
                    if (bad) begin
                        errors++;
                        $display("FAIL %s: got snap=%0b run=%0b fin=%0b erro=%0b busy=%0b din=%h pc=%0d cyc=%0d; required snap=%0b run=%0b fin=%0b erro=%0b busy=%0b din=%h(chk %0b) pc=%0d(chk %0b) cyc=%0d",
                                 cur.name, snap, Run, Finished, Erro, Busy, DIN, PC, cyc,
                                 cur.snapshot, cur.run, cur.fin, cur.erro, cur.busy,
                                 cur.din, cur.chk_din, cur.pc, cur.chk_pc, cur.cyc);
                    end
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    function automatic void push_evt(input string name, input bit is_snap,
                                     input logic run, input logic fin, input logic erro,
                                     input logic busy, input logic [15:0] din, input bit chk_din,
                                     input logic [3:0] pc, input bit chk_pc, input int c);
        exp_t e;
        e.name = name; e.snapshot = is_snap; e.run = run; e.fin = fin; e.erro = erro;
        e.busy = busy; e.din = din; e.chk_din = chk_din; e.pc = pc; e.chk_pc = chk_pc; e.cyc = c;
        sb.push_back(e);
    endfunction

    function automatic void push_run(input string name, input logic [15:0] din, input int c);
        push_evt(name, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, din, 1'b1, 4'd0, 1'b0, c);
    endfunction

    function automatic void push_fin(input string name, input logic [3:0] pc, input int c);
        push_evt(name, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0, 1'b0, pc, 1'b1, c);
    endfunction

    function automatic void push_err(input string name, input logic [3:0] pc, input int c);
        push_evt(name, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0, 1'b0, pc, 1'b1, c);
    endfunction

    task automatic tick();
        @(negedge Clock);
        snap = 1'b0;
    endtask

    // Full-state check at the current negedge.
    task automatic snap_chk(input string name, input logic [15:0] din, input logic run,
                            input logic busy, input logic [3:0] pc);
        push_evt(name, 1'b1, run, 1'b0, 1'b0, busy, din, 1'b1, pc, 1'b1, -1);
        snap = 1'b1;
    endtask

    task automatic load(input logic [3:0] a, input logic [15:0] d);
        LoadEn = 1'b1; LoadAddr = a; LoadData = d;
        tick();
        LoadEn = 1'b0;
    endtask

    task automatic start(input logic [4:0] len, output int t0);
        t0 = cyc;
        Start = 1'b1; ProgLen = len;
        tick();
        Start = 1'b0;
    endtask

    task automatic pulse_done();
        Done = 1'b1;
        tick();
        Done = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    int t0;

    initial begin
        Resetn = 1'b0; Start = 1'b0; ProgLen = '0; LoadEn = 1'b0;
        LoadAddr = '0; LoadData = '0; Done = 1'b0;
        tick(); tick();
        snap_chk("reset_state", 16'h0000, 1'b0, 1'b0, 4'd0);
        tick(); Resetn = 1'b1;
        tick();

        // mv R0,R1 single word
        load(4'd0, 16'h0001);
        start(5'd1, t0);
        push_run("mv_run", 16'h0001, t0 + 2);
        push_fin("mv_fin", 4'd1, t0 + 4);
        tick(); tick();
        pulse_done();
        tick(); snap_chk("mv_idle", 16'h0001, 1'b0, 1'b0, 4'd1);

        // mvi R0, #5 two words
        load(4'd0, 16'h0040); load(4'd1, 16'h0005);
        start(5'd2, t0);
        push_run("mvi_run", 16'h0040, t0 + 2);
        tick();
        tick(); snap_chk("mvi_imm_word", 16'h0005, 1'b0, 1'b1, 4'd2);
        push_fin("mvi_fin", 4'd2, t0 + 5);
        tick();
        pulse_done();
        tick(); snap_chk("mvi_idle", 16'h0005, 1'b0, 1'b0, 4'd2);

        // mvi as the last word: truncated
        start(5'd1, t0);
        push_run("trunc_run", 16'h0040, t0 + 2);
        push_err("trunc_err", 4'd1, t0 + 3);
        tick(); tick();
        tick(); snap_chk("trunc_idle", 16'h0040, 1'b0, 1'b0, 4'd1);

        // watchdog: Done never arrives
        load(4'd0, 16'h0010);
        start(5'd1, t0);
        push_run("wd_run", 16'h0010, t0 + 2);
        repeat (14) tick();
        tick(); snap_chk("wd_still_wait", 16'h0010, 1'b0, 1'b1, 4'd1);
        push_err("wd_err", 4'd1, t0 + 17);
        tick();
        tick(); snap_chk("wd_idle", 16'h0010, 1'b0, 1'b0, 4'd1);
        pulse_done();   // Done while idle must have no effect
        tick();

        // reset during WAIT of a 3-word program, then rerun
        load(4'd0, 16'h0001); load(4'd1, 16'h0048); load(4'd2, 16'h0007);
        start(5'd3, t0);
        push_run("rst_run", 16'h0001, t0 + 2);
        tick();
        tick(); Resetn = 1'b0; snap_chk("rst_async", 16'h0000, 1'b0, 1'b0, 4'd0);
        tick(); Resetn = 1'b1;
        tick();
        start(5'd3, t0);
        push_run("rerun_w0", 16'h0001, t0 + 2);
        tick();
        tick();
        push_run("rerun_w1", 16'h0048, t0 + 5);
        pulse_done();
        tick();
        tick(); snap_chk("rerun_imm", 16'h0007, 1'b0, 1'b1, 4'd3);
        // Start and a memory write while busy must both be ignored
        Start = 1'b1; ProgLen = 5'd1; LoadEn = 1'b1; LoadAddr = 4'd0; LoadData = 16'hFFFF;
        tick(); Start = 1'b0; LoadEn = 1'b0;
        push_fin("rerun_fin", 4'd3, t0 + 8);
        pulse_done();
        tick(); snap_chk("rerun_idle", 16'h0007, 1'b0, 1'b0, 4'd3);

        // mem[0] still holds the pre-reset program word
        start(5'd1, t0);
        push_run("mem_kept", 16'h0001, t0 + 2);
        push_fin("mem_kept_fin", 4'd1, t0 + 4);
        tick(); tick();
        pulse_done();
        tick();

        // empty program: Finished only
        start(5'd0, t0);
        push_fin("len0_fin", 4'd1, t0 + 1);
        tick(); snap_chk("len0_idle", 16'h0001, 1'b0, 1'b0, 4'd1);

        // 16 sub instructions, PC wraps
        for (int i = 0; i < 16; i++) load(i[3:0], 16'h00C8);
        start(5'd16, t0);
        tick();
        for (int i = 0; i < 16; i++) begin
            push_run($sformatf("sub_run%0d", i), 16'h00C8, t0 + 2 + 2 * i);
            if (i == 15) push_fin("sub_fin", 4'd0, t0 + 33);
            pulse_done();
            tick();
        end
`ifdef SEQUENCIADOR_LOOP_EN
        push_run("loop_run17", 16'h00C8, t0 + 35);
        tick();
        tick(); Resetn = 1'b0;
        tick(); Resetn = 1'b1;
        snap_chk("loop_reset", 16'h0000, 1'b0, 1'b0, 4'd0);
`else
        snap_chk("sub_idle", 16'h00C8, 1'b0, 1'b0, 4'd0);
`endif

        tick(); final_req = 1'b1;
        tick(); final_req = 1'b0;
        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not end, required end before 200000");
        $fatal(1);
    end

endmodule

// File: doc/sequenciador_din.md
SEQUENCIADOR_DIN -- requirements
Module: sequenciador_din

Interface
REQ-001 SHALL have exactly one clock, Clock (rising edge); reset Resetn is asynchronous and active-low.
REQ-002 Clock  input  1  system clock.
REQ-003 Resetn  input  1  asynchronous active-low reset.
REQ-004 Start  input  1  pulse; begins program issue when idle.
REQ-005 ProgLen  input  5  words in program (0..16); sampled on accepted Start.
REQ-006 LoadEn / LoadAddr / LoadData  input  1/4/16  program-memory write port.
REQ-007 Done  input  1  instruction-complete from processador_multiciclo.
REQ-008 DIN  output  16  registered word driven to processador_multiciclo DIN.
REQ-009 Run  output  1  registered; high one cycle per instruction issue.
REQ-010 Busy  output  1  high in any state other than IDLE.
REQ-011 Finished  output  1  one-cycle pulse on program completion.
REQ-012 Erro  output  1  one-cycle pulse on abort (timeout or truncated mvi).
REQ-013 PC  output  4  address of next word to read.

Function
REQ-014 Instruction word layout: DIN[8:6] opcode, DIN[5:3] Rx, DIN[2:0] Ry, DIN[15:9] zero; opcode 001 (mvi) occupies two words: instruction, then immediate.
REQ-015 States: IDLE, ISSUE, IMM, WAIT, END.
REQ-016 IDLE: Run=0, DIN holds last value; Start with ProgLen!=0 -> ISSUE, PC=0, issued-count=0; Start with ProgLen=0 -> END directly (Finished pulse, no Run).
REQ-017 ISSUE (1 cycle): DIN<=mem[PC], Run<=1, PC<=PC+1, count<=count+1; next IMM if mem[PC][8:6]==001, else WAIT.
REQ-018 IMM (1 cycle): if count==ProgLen -> Erro pulse, IDLE; else DIN<=mem[PC], Run<=0, PC<=PC+1, count<=count+1, -> WAIT.
REQ-019 WAIT: Run=0, DIN held; on Done=1 -> END if count==ProgLen, else ISSUE.
REQ-020 Watchdog: 4-bit counter cleared on entering WAIT; 15 cycles in WAIT without Done -> Erro pulse, IDLE.
REQ-021 END (1 cycle): Finished=1 -> IDLE (see REQ-027).
REQ-022 PC wraps 15->0; count is 5 bits so ProgLen=16 is legal.
REQ-023 Start while Busy ignored; Done while not in WAIT ignored.
REQ-024 LoadEn honoured only in IDLE (synchronous write); ignored while Busy; read-during-write in same cycle returns old data.
REQ-025 Issue latency: Start accepted at edge N -> Run=1 and DIN valid after edge N+1.

Reset
REQ-026 Resetn low at any time (including mid-program) SHALL immediately force IDLE, DIN=0, Run=0, Busy=0, Finished=0, Erro=0, PC=0, counters=0; program memory contents are not cleared.

Configuration
REQ-027 Macro SEQUENCIADOR_LOOP_EN: defined -> END pulses Finished then goes to ISSUE with PC=0, count=0 (continuous repetition until reset); undefined -> END returns to IDLE.

Structure
REQ-028 Shared package pacote_processador SHALL hold opcode constants (MV=000, MVI=001, ADD=010, SUB=011), word width 16, and the state encoding.
REQ-029 Sub-module memoria_programa: 16x16 storage, synchronous write, combinational read.

Verification
REQ-030 Load mem[0]=0x0001 (mv R0,R1), ProgLen=1, Start; Done after 2 cycles -> one Run pulse, DIN=0x0001, Finished one cycle later, PC=1.
REQ-031 Load mem[0]=0x0040 (mvi R0), mem[1]=0x0005, ProgLen=2 -> ISSUE DIN=0x0040 Run=1, next cycle DIN=0x0005 Run=0, Finished after Done, PC=2.
REQ-032 ProgLen=1, mem[0]=0x0040 -> Erro pulse after ISSUE, no Finished, returns IDLE.
REQ-033 Done never asserted -> Erro exactly 15 cycles after entering WAIT, Busy falls.
REQ-034 Resetn low during WAIT of a 3-word program -> all outputs 0 immediately; subsequent Start reruns from PC=0 with memory intact.
REQ-035 ProgLen=16 of sub instructions (0x00C8) -> 16 Run pulses, PC wraps to 0, Finished once; with SEQUENCIADOR_LOOP_EN a 17th Run follows Finished.
